status_stack: RTL and testbench

STATUS_STACK -- requirements
Module: status_stack

---
 rtl/status_stack_if.sv | 28 ++
 rtl/status_stack.sv | 68 ++++++
 tb/tb_status_stack.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/status_stack_if.sv
// Handshake bundle between the ALU/sequencer and the flag stack.
interface status_stack_if #(
    parameter int FLAGS = 4,
    parameter int DEPTH = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             notLoad;
    logic [FLAGS-1:0] loadMask;
    logic [FLAGS-1:0] flagsIn;
    logic             push;
    logic             pop;
    logic [FLAGS-1:0] flagsOut;
    logic [DW-1:0]    depthOut;
    logic             full;
    logic             empty;
    logic             error;

    modport master (
        output notLoad, loadMask, flagsIn, push, pop,
        input  flagsOut, depthOut, full, empty, error
    );

    modport slave (
        input  notLoad, loadMask, flagsIn, push, pop,
        output flagsOut, depthOut, full, empty, error
    );
endinterface

// File: rtl/status_stack.sv
// Live status-flag register with a LIFO save stack for interrupt/call entry
// and return; sticky error on overflow or underflow.
module status_stack #(
    parameter int FLAGS = 4,
    parameter int DEPTH = 4
) (
    input logic          clock,
    input logic          reset,
    status_stack_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLAGS-1:0] flags_q, flags_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             error_q, error_d;
    logic [FLAGS-1:0] stack_q [DEPTH];

    logic             full, empty;
    logic             do_push, do_pop, ovf, unf;
    logic [DW-1:0]    top;
    logic [FLAGS-1:0] loaded;

    assign full    = (depth_q == DW'(DEPTH));
    assign empty   = (depth_q == '0);
    assign do_push = bus.push & ~bus.pop & ~full;
    assign do_pop  = bus.pop & ~bus.push & ~empty;
    assign ovf     = bus.push & ~bus.pop & full;
    assign unf     = bus.pop & ~bus.push & empty;
    assign top     = depth_q - DW'(1);
    assign loaded  = (flags_q & ~bus.loadMask) | (bus.flagsIn & bus.loadMask);

    always_comb begin
        flags_d = flags_q;
        depth_d = depth_q;
        error_d = error_q | ovf | unf;
        if (do_pop) begin
            flags_d = stack_q[top[AW-1:0]];
            depth_d = top;
        end else begin
            if (!bus.notLoad) flags_d = loaded;
            if (do_push) depth_d = depth_q + DW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flags_q <= '0;
            depth_q <= '0;
            error_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            error_q <= error_d;
        end
    end

    // Slot storage is never reset; depth_q alone decides what is valid.
    always_ff @(posedge clock) begin
        if (!reset && do_push) stack_q[depth_q[AW-1:0]] <= flags_q;
    end

    assign bus.flagsOut = flags_q;
    assign bus.depthOut = depth_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.error    = error_q;
endmodule

// File: tb/tb_status_stack.sv
// Directed self-checking bench for status_stack (FLAGS=4, DEPTH=2).
module tb_status_stack;
    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   passed = 0;

    status_stack_if #(.FLAGS(4), .DEPTH(2)) bus ();

    status_stack #(.FLAGS(4), .DEPTH(2)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic idle();
        bus.notLoad  = 1'b1;
        bus.loadMask = 4'b0000;
        bus.flagsIn  = 4'b0000;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        reset        = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic load(input logic [3:0] m, input logic [3:0] f);
        bus.notLoad  = 1'b0;
        bus.loadMask = m;
        bus.flagsIn  = f;
    endtask

    task automatic chk(input string nm, input logic [3:0] fl,
                       input logic [1:0] d, input logic e,
                       input logic er, input logic fu);
        total++;
        if (bus.flagsOut !== fl || bus.depthOut !== d || bus.empty !== e
            || bus.error !== er || bus.full !== fu)
            $display("FAIL %s got f=%b d=%0d e=%b err=%b full=%b exp f=%b d=%0d e=%b err=%b full=%b",
                     nm, bus.flagsOut, bus.depthOut, bus.empty, bus.error,
                     bus.full, fl, d, e, er, fu);
        else passed++;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        load(4'b1111, 4'b1111);
        step();
        chk("reset", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_load();
        load(4'b1111, 4'b1011);
        step();
        chk("load_all", 4'b1011, 2'd0, 1'b1, 1'b0, 1'b0);
        bus.flagsIn  = 4'b0000;
        bus.loadMask = 4'b1111;
        step();
        chk("load_off_hold", 4'b1011, 2'd0, 1'b1, 1'b0, 1'b0);
        load(4'b0010, 4'b0000);
        step();
        chk("load_masked", 4'b1001, 2'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_push_pop();
        bus.push = 1'b1;
        load(4'b1111, 4'b0000);
        step();
        chk("push_load", 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
        bus.pop = 1'b1;
        load(4'b1111, 4'b1111);
        step();
        chk("pop_ignores_load", 4'b1001, 2'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_full();
        load(4'b1111, 4'b0001);
        step();
        chk("pre_0001", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
        bus.push = 1'b1;
        load(4'b1111, 4'b0010);
        step();
        chk("push1", 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0);
        bus.push = 1'b1;
        load(4'b1111, 4'b0100);
        step();
        chk("push2_full", 4'b0100, 2'd2, 1'b0, 1'b0, 1'b1);
        bus.push = 1'b1;
        load(4'b0001, 4'b0001);
        step();
        chk("overflow", 4'b0101, 2'd2, 1'b0, 1'b1, 1'b1);
        bus.pop = 1'b1;
        step();
        chk("pop_lifo1", 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0);
        bus.pop = 1'b1;
        step();
        chk("pop_lifo2", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        step();
        chk("error_sticky", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_underflow();
        reset = 1'b1;
        step();
        bus.pop = 1'b1;
        load(4'b0100, 4'b0100);
        step();
        chk("underflow_load", 4'b0100, 2'd0, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        bus.push = 1'b1;
        step();
        chk("push_after_rst", 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        load(4'b1111, 4'b0110);
        step();
        chk("push_pop_both", 4'b0110, 2'd1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bus.push = 1'b1;
        step();
        chk("fill", 4'b0110, 2'd2, 1'b0, 1'b0, 1'b1);
        bus.push = 1'b1;
        step();
        chk("fill_ovf", 4'b0110, 2'd2, 1'b0, 1'b1, 1'b1);
        reset    = 1'b1;
        bus.push = 1'b1;
        step();
        chk("reset_over_push", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
        bus.pop = 1'b1;
        step();
        chk("pop_after_reset", 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        idle();
        test_reset();
        test_load();
        test_push_pop();
        test_full();
        test_underflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
